// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus bundle between the load/store sequencer (master) and memory (slave).
interface mem_access_ctrl_if;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWdata;
  logic [3:0]  busBe;
  logic        busAck;
  logic [31:0] busRdata;
  logic        busErr;

  modport master (
    output busReq, busWe, busAddr, busWdata, busBe,
    input  busAck, busRdata, busErr
  );

  modport slave (
    input  busReq, busWe, busAddr, busWdata, busBe,
    output busAck, busRdata, busErr
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Multi-cycle load/store sequencer: stalls the pipeline around one req/ack bus
// transaction, steers byte lanes, checks alignment and enforces a bus timeout.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     memRead,
  input  logic                     memWrite,
  input  logic [2:0]               funct3,
  input  logic [31:0]              addr,
  input  logic [31:0]              storeData,
  input  logic [4:0]               rdIn,
  input  logic                     flush,
  output logic                     stall,
  mem_access_ctrl_if.master        bus,
  output logic                     loadValid,
  output logic [31:0]              loadData,
  output logic [4:0]               rdOut,
  output logic                     fault,
  output logic [1:0]               faultCause
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t      state_q, state_d;

  logic        req_valid, bad_size, misaligned;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_ext;
  logic [16:0] count_inc;
  logic        bus_timeout, bus_end, squash_now;

  logic [15:0] count_q;
  logic        is_write_q, squash_q;
  logic [2:0]  size_q;
  logic [1:0]  lane_q;
  logic        bus_req_q, bus_we_q;
  logic [31:0] bus_addr_q, bus_wdata_q;
  logic [3:0]  bus_be_q;

  assign bus.busReq   = bus_req_q;
  assign bus.busWe    = bus_we_q;
  assign bus.busAddr  = bus_addr_q;
  assign bus.busWdata = bus_wdata_q;
  assign bus.busBe    = bus_be_q;

  // Request qualification and store lane steering, all from the live inputs.
  always_comb begin
    req_valid  = (memRead | memWrite) & ~flush;
    bad_size   = (funct3 == 3'd3) | (funct3 == 3'd6) | (funct3 == 3'd7) |
                 (memWrite & funct3[2]);
    misaligned = ((funct3[1:0] == 2'b01) & addr[0]) |
                 ((funct3 == 3'd2) & (addr[1:0] != 2'b00));
    lane_be    = 4'b1111;
    lane_wdata = storeData;
    case (funct3[1:0])
      2'b00: begin
        lane_be    = 4'b0001 << addr[1:0];
        lane_wdata = {4{storeData[7:0]}};
      end
      2'b01: begin
        lane_be    = 4'b0011 << addr[1:0];
        lane_wdata = {2{storeData[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = storeData;
      end
    endcase
  end

  // Load lane extraction uses the latched offset and size, not the live inputs.
  always_comb begin
    sel_byte = bus.busRdata[{lane_q, 3'b000} +: 8];
    sel_half = lane_q[1] ? bus.busRdata[31:16] : bus.busRdata[15:0];
    case (size_q)
      3'd0:    load_ext = {{24{sel_byte[7]}}, sel_byte};
      3'd4:    load_ext = {24'd0, sel_byte};
      3'd1:    load_ext = {{16{sel_half[15]}}, sel_half};
      3'd5:    load_ext = {16'd0, sel_half};
      default: load_ext = bus.busRdata;
    endcase
  end

  always_comb begin
    count_inc   = {1'b0, count_q} + 17'd1;
    bus_timeout = (count_inc == 17'(TIMEOUT_CYCLES));
    bus_end     = bus.busErr | bus.busAck | bus_timeout;
    squash_now  = squash_q | flush;
  end

  always_ff @(posedge clk) begin
    if (!rstN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          stall   = 1'b1;
          state_d = (bad_size | misaligned) ? DONE : BUS;
        end
      end
      BUS: begin
        stall = 1'b1;
        if (bus_end) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes default low every cycle so DONE produces at most a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      count_q     <= '0;
      is_write_q  <= 1'b0;
      squash_q    <= 1'b0;
      size_q      <= '0;
      lane_q      <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      loadValid   <= 1'b0;
      loadData    <= '0;
      rdOut       <= '0;
      fault       <= 1'b0;
      faultCause  <= '0;
    end else begin
      loadValid <= 1'b0;
      fault     <= 1'b0;
      case (state_q)
        IDLE: begin
          count_q  <= '0;
          squash_q <= 1'b0;
          if (req_valid) begin
            is_write_q <= memWrite;
            size_q     <= funct3;
            lane_q     <= addr[1:0];
            rdOut      <= rdIn;
            if (bad_size | misaligned) begin
              fault      <= 1'b1;
              faultCause <= 2'b01;
            end else begin
              bus_req_q   <= 1'b1;
              bus_we_q    <= memWrite;
              bus_addr_q  <= {addr[31:2], 2'b00};
              bus_be_q    <= memWrite ? lane_be : 4'b1111;
              bus_wdata_q <= memWrite ? lane_wdata : 32'd0;
            end
          end
        end
        BUS: begin
          count_q  <= count_inc[15:0];
          squash_q <= squash_now;
          if (bus_end) begin
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            bus_be_q  <= 4'b0000;
            if (bus.busErr) begin
              fault      <= ~squash_now;
              faultCause <= 2'b10;
            end else if (bus.busAck) begin
              if (!is_write_q) begin
                loadData  <= load_ext;
                loadValid <= ~squash_now;
              end
            end else begin
              fault      <= ~squash_now;
              faultCause <= 2'b11;
            end
          end
        end
        DONE: begin
          count_q  <= '0;
          squash_q <= 1'b0;
        end
        default: begin
          count_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: expected writebacks/faults are queued at
// stimulus time and popped when the DUT strobes loadValid or fault.
module tb_mem_access_ctrl;

  typedef struct {
    logic        is_fault;
    logic [31:0] data;
    logic [4:0]  rd;
    logic [1:0]  cause;
  } exp_t;

  logic        clk;
  logic        rstN;
  logic        memRead, memWrite, flush;
  logic [2:0]  funct3;
  logic [31:0] addr, storeData;
  logic [4:0]  rdIn;
  logic        stall, loadValid, fault;
  logic [31:0] loadData;
  logic [4:0]  rdOut;
  logic [1:0]  faultCause;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  mem_access_ctrl_if bus();

  mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rstN       (rstN),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .funct3     (funct3),
    .addr       (addr),
    .storeData  (storeData),
    .rdIn       (rdIn),
    .flush      (flush),
    .stall      (stall),
    .bus        (bus),
    .loadValid  (loadValid),
    .loadData   (loadData),
    .rdOut      (rdOut),
    .fault      (fault),
    .faultCause (faultCause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard consumer: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (loadValid || fault) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_strobe: got loadValid=%b fault=%b cause=%b, expected no strobe",
                 loadValid, fault, faultCause);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (loadValid !== !e.is_fault || fault !== e.is_fault) begin
          errors++;
          $display("[TB] FAIL strobe_kind: got loadValid=%b fault=%b, expected fault=%b",
                   loadValid, fault, e.is_fault);
        end else if (!e.is_fault && (loadData !== e.data || rdOut !== e.rd)) begin
          errors++;
          $display("[TB] FAIL load_result: got data=%h rd=%0d, expected data=%h rd=%0d",
                   loadData, rdOut, e.data, e.rd);
        end else if (e.is_fault && faultCause !== e.cause) begin
          errors++;
          $display("[TB] FAIL fault_cause: got %b, expected %b", faultCause, e.cause);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic push_load(input logic [31:0] data, input logic [4:0] rd);
    exp_t e;
    e.is_fault = 1'b0; e.data = data; e.rd = rd; e.cause = 2'b00;
    sb.push_back(e);
  endtask

  task automatic push_fault(input logic [1:0] cause);
    exp_t e;
    e.is_fault = 1'b1; e.data = '0; e.rd = '0; e.cause = cause;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      memRead = 0; memWrite = 0; flush = 0; funct3 = 0; addr = 0;
      storeData = 0; rdIn = 0; bus.busAck = 0; bus.busErr = 0; bus.busRdata = 0;
    end
  endtask

  // Drives one access starting at the next cycle; ack/err/flush are raised on the
  // given cycle index (0 = accept cycle, -1 = never). Returns once stall drops.
  task automatic applyStimulus(
    input  logic        rd_en, wr_en,
    input  logic [2:0]  f3,
    input  logic [31:0] a, sd,
    input  logic [4:0]  rd,
    input  logic [31:0] rdata,
    input  int          ack_at, err_at, flush_at,
    output int          stall_cycles, req_cycles,
    output logic [31:0] seen_addr, seen_wdata,
    output logic [3:0]  seen_be,
    output logic        seen_we,
    output logic        stable
  );
    int  cyc;
    bit  seen, done;
    stall_cycles = 0; req_cycles = 0; seen = 0; done = 0; stable = 1;
    seen_addr = '0; seen_wdata = '0; seen_be = '0; seen_we = 0;
    @(posedge clk); #1;
    cyc = 0;
    memRead = rd_en; memWrite = wr_en; funct3 = f3; addr = a; storeData = sd; rdIn = rd;
    bus.busRdata = rdata;
    bus.busAck = (cyc == ack_at); bus.busErr = (cyc == err_at); flush = (cyc == flush_at);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.busReq === 1'b1) begin
        if (!seen) begin
          seen = 1; seen_addr = bus.busAddr; seen_wdata = bus.busWdata;
          seen_be = bus.busBe; seen_we = bus.busWe;
        end else if (bus.busAddr !== seen_addr || bus.busWdata !== seen_wdata ||
                     bus.busBe !== seen_be || bus.busWe !== seen_we) begin
          stable = 0;
        end
        req_cycles++;
      end
      if (stall !== 1'b1) begin
        done = 1;
        break;
      end
      stall_cycles++;
      @(posedge clk); #1;
      cyc++;
      bus.busAck = (cyc == ack_at); bus.busErr = (cyc == err_at); flush = (cyc == flush_at);
    end
    if (!done) begin
      checks++; errors++;
      $display("[TB] FAIL access_bound: stall still %b after 40 cycles, expected release", stall);
    end
    #2;
  endtask

  task automatic test_reset();
    rstN = 0;
    memRead = 0; memWrite = 0; flush = 0; funct3 = 0; addr = 0; storeData = 0; rdIn = 0;
    bus.busAck = 0; bus.busErr = 0; bus.busRdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({stall, bus.busReq, bus.busWe, bus.busBe, loadValid, fault, faultCause} !== 11'd0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got stall=%b req=%b we=%b be=%b lv=%b fault=%b cause=%b, expected all 0",
               stall, bus.busReq, bus.busWe, bus.busBe, loadValid, fault, faultCause);
    end
    checks++;
    if ({bus.busAddr, bus.busWdata, loadData, rdOut} !== 101'd0) begin
      errors++;
      $display("[TB] FAIL reset_data: got addr=%h wdata=%h ldata=%h rd=%0d, expected all 0",
               bus.busAddr, bus.busWdata, loadData, rdOut);
    end
    @(posedge clk); #1;
    rstN = 1;
  endtask

  task automatic test_load_byte();
    int sc, rc; logic [31:0] sa, sw; logic [3:0] sbe; logic swe, st;
    $display("[TB] LB from 0x103");
    push_load(32'hFFFFFF80, 5'd7);
    applyStimulus(1, 0, 3'd0, 32'h103, 32'h0, 5'd7, 32'h80AABBCC, 1, -1, -1,
                  sc, rc, sa, sw, sbe, swe, st);
    checks++;
    if (sbe !== 4'b1111 || sa !== 32'h100 || swe !== 1'b0 || sw !== 32'h0) begin
      errors++;
      $display("[TB] FAIL lb_bus: got be=%b addr=%h we=%b wdata=%h, expected be=1111 addr=100 we=0 wdata=0",
               sbe, sa, swe, sw);
    end
    checks++;
    if (sc !== 2 || rc !== 1) begin
      errors++;
      $display("[TB] FAIL lb_timing: got stall=%0d req=%0d cycles, expected 2 and 1", sc, rc);
    end
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("[TB] FAIL lb_drain: got %0d pending, expected 0", sb.size());
    end
  endtask

  task automatic test_load_variants();
    logic [2:0]  f3s [6] = '{3'd4, 3'd0, 3'd1, 3'd5, 3'd1, 3'd2};
    logic [31:0] as  [6] = '{32'h101, 32'h102, 32'h402, 32'h402, 32'h400, 32'h404};
    logic [31:0] rds [6] = '{32'h0000F600, 32'h007F0000, 32'h80010000, 32'h80010000,
                             32'h00007FFE, 32'hDEADBEEF};
    logic [31:0] exs [6] = '{32'h000000F6, 32'h0000007F, 32'hFFFF8001, 32'h00008001,
                             32'h00007FFE, 32'hDEADBEEF};
    logic [31:0] bas [6] = '{32'h100, 32'h100, 32'h400, 32'h400, 32'h400, 32'h404};
    int          acks[6] = '{2, 1, 3, 1, 2, 2};
    $display("[TB] load size/sign variants, back to back");
    for (int i = 0; i < 6; i++) begin
      int sc, rc; logic [31:0] sa, sw; logic [3:0] sbe; logic swe, st;
      push_load(exs[i], 5'(i + 10));
      applyStimulus(1, 0, f3s[i], as[i], 32'hFFFFFFFF, 5'(i + 10), rds[i], acks[i], -1, -1,
                    sc, rc, sa, sw, sbe, swe, st);
      checks++;
      if (sa !== bas[i] || sbe !== 4'b1111 || swe !== 1'b0 || st !== 1'b1) begin
        errors++;
        $display("[TB] FAIL load%0d_bus: got addr=%h be=%b we=%b stable=%b, expected addr=%h be=1111 we=0 stable=1",
                 i, sa, sbe, swe, st, bas[i]);
      end
      checks++;
      if (sc !== acks[i] + 1 || rc !== acks[i]) begin
        errors++;
        $display("[TB] FAIL load%0d_timing: got stall=%0d req=%0d, expected %0d and %0d",
                 i, sc, rc, acks[i] + 1, acks[i]);
      end
    end
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("[TB] FAIL loads_drain: got %0d pending, expected 0", sb.size());
    end
    idle(1);
  endtask

  task automatic test_store();
    logic [2:0]  f3s [5] = '{3'd1, 3'd0, 3'd0, 3'd1, 3'd2};
    logic [31:0] as  [5] = '{32'h202, 32'h301, 32'h303, 32'h200, 32'h30C};
    logic [31:0] sds [5] = '{32'h1234ABCD, 32'h00000055, 32'hFFFFFFA7, 32'h00001234, 32'hCAFEF00D};
    logic [3:0]  bes [5] = '{4'b1100, 4'b0010, 4'b1000, 4'b0011, 4'b1111};
    logic [31:0] wds [5] = '{32'hABCDABCD, 32'h55555555, 32'hA7A7A7A7, 32'h12341234, 32'hCAFEF00D};
    logic [31:0] bas [5] = '{32'h200, 32'h300, 32'h300, 32'h200, 32'h30C};
    logic        both[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int          acks[5] = '{1, 2, 1, 3, 1};
    $display("[TB] store lane steering");
    for (int i = 0; i < 5; i++) begin
      int sc, rc; logic [31:0] sa, sw; logic [3:0] sbe; logic swe, st;
      applyStimulus(both[i], 1, f3s[i], as[i], sds[i], 5'd2, 32'h0, acks[i], -1, -1,
                    sc, rc, sa, sw, sbe, swe, st);
      checks++;
      if (sbe !== bes[i] || sw !== wds[i] || sa !== bas[i] || swe !== 1'b1 || st !== 1'b1) begin
        errors++;
        $display("[TB] FAIL store%0d_bus: got be=%b wdata=%h addr=%h we=%b stable=%b, expected be=%b wdata=%h addr=%h we=1 stable=1",
                 i, sbe, sw, sa, swe, st, bes[i], wds[i], bas[i]);
      end
      checks++;
      if (sc !== acks[i] + 1) begin
        errors++;
        $display("[TB] FAIL store%0d_timing: got stall=%0d, expected %0d", i, sc, acks[i] + 1);
      end
    end
    idle(1);
  endtask

  task automatic test_misaligned();
    logic        rde [9] = '{1, 1, 1, 1, 1, 0, 1, 1, 0};
    logic        wre [9] = '{0, 0, 0, 0, 0, 1, 0, 0, 1};
    logic [2:0]  f3s [9] = '{3'd2, 3'd3, 3'd1, 3'd5, 3'd2, 3'd4, 3'd6, 3'd7, 3'd2};
    logic [31:0] as  [9] = '{32'h101, 32'h100, 32'h003, 32'h001, 32'h102, 32'h100,
                             32'h100, 32'h100, 32'h302};
    $display("[TB] misaligned and illegal-size accesses");
    for (int i = 0; i < 9; i++) begin
      int sc, rc; logic [31:0] sa, sw; logic [3:0] sbe; logic swe, st;
      push_fault(2'b01);
      applyStimulus(rde[i], wre[i], f3s[i], as[i], 32'h0, 5'd4, 32'h0, 1, -1, -1,
                    sc, rc, sa, sw, sbe, swe, st);
      checks++;
      if (rc !== 0 || sc !== 1) begin
        errors++;
        $display("[TB] FAIL misalign%0d: got req=%0d stall=%0d cycles, expected 0 and 1", i, rc, sc);
      end
    end
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("[TB] FAIL misalign_drain: got %0d pending, expected 0", sb.size());
    end
    idle(1);
  endtask

  task automatic test_timeout();
    int sc, rc; logic [31:0] sa, sw; logic [3:0] sbe; logic swe, st;
    $display("[TB] timeout with no ack");
    push_fault(2'b11);
    applyStimulus(1, 0, 3'd2, 32'h500, 32'h0, 5'd9, 32'h0, -1, -1, -1,
                  sc, rc, sa, sw, sbe, swe, st);
    checks++;
    if (rc !== 4 || sc !== 5 || st !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_len: got req=%0d stall=%0d stable=%b, expected 4, 5, 1", rc, sc, st);
    end
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("[TB] FAIL timeout_drain: got %0d pending, expected 0", sb.size());
    end
    idle(1);
  endtask

  task automatic test_bus_err();
    int sc, rc; logic [31:0] sa, sw; logic [3:0] sbe; logic swe, st;
    $display("[TB] bus error, alone and together with ack");
    push_fault(2'b10);
    applyStimulus(1, 0, 3'd2, 32'h700, 32'h0, 5'd5, 32'h11111111, 2, 2, -1,
                  sc, rc, sa, sw, sbe, swe, st);
    checks++;
    if (rc !== 2 || sc !== 3) begin
      errors++;
      $display("[TB] FAIL err_ack_timing: got req=%0d stall=%0d, expected 2 and 3", rc, sc);
    end
    push_fault(2'b10);
    applyStimulus(0, 1, 3'd2, 32'h704, 32'h5A5A5A5A, 5'd5, 32'h0, -1, 1, -1,
                  sc, rc, sa, sw, sbe, swe, st);
    checks++;
    if (rc !== 1 || sc !== 2) begin
      errors++;
      $display("[TB] FAIL err_store_timing: got req=%0d stall=%0d, expected 1 and 2", rc, sc);
    end
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("[TB] FAIL err_drain: got %0d pending, expected 0", sb.size());
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    int sc, rc; logic [31:0] sa, sw; logic [3:0] sbe; logic swe, st;
    $display("[TB] flush in BUS then immediate next access");
    applyStimulus(1, 0, 3'd5, 32'h002, 32'h0, 5'd6, 32'h9876FFFF, 3, -1, 1,
                  sc, rc, sa, sw, sbe, swe, st);
    checks++;
    if (sc !== 4 || rc !== 3) begin
      errors++;
      $display("[TB] FAIL flush_timing: got stall=%0d req=%0d, expected 4 and 3", sc, rc);
    end
    push_load(32'h01020304, 5'd8);
    applyStimulus(1, 0, 3'd2, 32'h010, 32'h0, 5'd8, 32'h01020304, 1, -1, -1,
                  sc, rc, sa, sw, sbe, swe, st);
    checks++;
    if (sc !== 2 || rc !== 1 || sa !== 32'h10) begin
      errors++;
      $display("[TB] FAIL after_flush: got stall=%0d req=%0d addr=%h, expected 2, 1, 10", sc, rc, sa);
    end
    applyStimulus(1, 0, 3'd2, 32'h020, 32'h0, 5'd8, 32'h0, 1, -1, 0,
                  sc, rc, sa, sw, sbe, swe, st);
    checks++;
    if (sc !== 0 || rc !== 0) begin
      errors++;
      $display("[TB] FAIL idle_flush: got stall=%0d req=%0d, expected 0 and 0", sc, rc);
    end
    idle(2);
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("[TB] FAIL flush_drain: got %0d pending, expected 0", sb.size());
    end
  endtask

  task automatic test_spurious_ack();
    $display("[TB] ack/err outside BUS");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.busAck = 1; bus.busErr = (i == 1);
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || bus.busReq !== 1'b0) begin
        errors++;
        $display("[TB] FAIL spurious_ack%0d: got stall=%b req=%b, expected 0 and 0", i, stall, bus.busReq);
      end
    end
    idle(2);
  endtask

  task automatic test_reset_mid_bus();
    int sc, rc; logic [31:0] sa, sw; logic [3:0] sbe; logic swe, st;
    $display("[TB] reset during BUS");
    @(posedge clk); #1;
    memRead = 1; funct3 = 3'd2; addr = 32'h600; rdIn = 5'd3; bus.busAck = 0; bus.busErr = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstN = 0; memRead = 0;
    @(negedge clk);
    checks++;
    if (bus.busReq !== 1'b1 || stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset_bus: got req=%b stall=%b, expected 1 and 1", bus.busReq, stall);
    end
    @(posedge clk); #1;
    rstN = 1;
    @(negedge clk);
    checks++;
    if ({stall, bus.busReq, bus.busWe, bus.busBe, loadValid, fault} !== 9'd0 ||
        bus.busAddr !== 32'd0 || bus.busWdata !== 32'd0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got stall=%b req=%b we=%b be=%b lv=%b fault=%b addr=%h, expected all 0",
               stall, bus.busReq, bus.busWe, bus.busBe, loadValid, fault, bus.busAddr);
    end
    idle(3);
    push_load(32'hFFFFFFAB, 5'd12);
    applyStimulus(1, 0, 3'd0, 32'h601, 32'h0, 5'd12, 32'h0000AB00, 2, -1, -1,
                  sc, rc, sa, sw, sbe, swe, st);
    checks++;
    if (sc !== 3 || rc !== 2 || sa !== 32'h600) begin
      errors++;
      $display("[TB] FAIL post_reset_access: got stall=%0d req=%0d addr=%h, expected 3, 2, 600", sc, rc, sa);
    end
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("[TB] FAIL reset_drain: got %0d pending, expected 0", sb.size());
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_load_variants();
    test_store();
    test_misaligned();
    test_timeout();
    test_bus_err();
    test_back_to_back();
    test_spurious_ack();
    test_reset_mid_bus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
